// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage.
//   state_t      : memory-access FSM state encoding
//   TIMEOUT_DEF  : default bus-timeout limit in WAIT cycles
//   CTR_W        : width of the timeout counter (holds up to 255)
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned CTR_W       = 8;

endpackage

// File: rtl/mem_access_timeout_ctr.sv
// Bus-timeout counter for the memory-access stage.
// Counts WAIT cycles that pass without an acknowledge.
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   i_clr  : clear count to 0 (new access accepted)
//   i_en   : advance count by one
//   o_tc   : count has reached TIMEOUT-1
module timeout_ctr
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CTR_W-1:0] TC_VAL = CTR_W'(TIMEOUT - 1);

    logic [CTR_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/mem_access.sv
// Memory-access stage placed after EX. Turns load/store requests into a
// single held bus request, stalls the pipeline while it is outstanding,
// and returns load data with a one-cycle valid pulse. A bus that never
// acknowledges is abandoned after TIMEOUT WAIT cycles and raises a sticky
// error flag.
//   clk, rst_n           : clock, synchronous active-low reset
//   addr, wrt_data       : effective address / store data from EX
//   re, we, hlt          : load request, store request, processor halted
//   rd_data, rd_vld      : load result and its one-cycle valid pulse
//   stall                : freeze PC and upstream stages
//   err                  : sticky bus-timeout flag
//   mem_req/we/addr/wdata: bus request side
//   mem_ack, mem_rdata   : bus completion and read data
//
// state | meaning
// IDLE  | no access outstanding, accepts a new request when not halted
// WAIT  | bus request held, waiting for mem_ack or timeout
// RESP  | access finished, pulses rd_vld for loads
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned DW      = 16,
    parameter int unsigned AW      = 16,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wrt_data,
    input  logic          re,
    input  logic          we,
    input  logic          hlt,
    output logic [DW-1:0] rd_data,
    output logic          rd_vld,
    output logic          stall,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_accept;
    logic          w_ctr_clr;
    logic          w_ctr_en;
    logic          w_tc;
    logic [DW-1:0] r_rd_data;
    logic          r_err;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    assign w_accept = (r_state == IDLE) && (re || we) && !hlt;

    timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_ctr_clr),
        .i_en  (w_ctr_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        stall       = 1'b0;
        rd_vld      = 1'b0;
        w_ctr_clr   = 1'b0;
        w_ctr_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    stall       = 1'b1;
                    w_ctr_clr   = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_ack) begin
                    w_state_nxt = RESP;
                end else begin
                    w_ctr_en = 1'b1;
                    if (w_tc) begin
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                // loads and timed-out loads both report; stores never do
                rd_vld      = !r_mem_we;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_rd_data   <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem_addr  <= addr;
                r_mem_wdata <= wrt_data;
                r_mem_we    <= we;
            end
            if (r_state == WAIT) begin
                if (mem_ack) begin
                    if (!r_mem_we) begin
                        r_rd_data <= mem_rdata;
                    end
                end else if (w_tc) begin
                    r_err     <= 1'b1;
                    r_rd_data <= '0;
                end
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign err       = r_err;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] wrt_data;
    logic          re, we, hlt;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rd_data;
    logic          rd_vld, stall, err, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    logic          re2, we2, mem_ack2;
    logic [DW-1:0] rd_data2;
    logic          rd_vld2, stall2, err2, mem_req2, mem_we2;
    logic [AW-1:0] mem_addr2;
    logic [DW-1:0] mem_wdata2;

    int n_chk = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;

    always #5 clk = ~clk;

    mem_access #(.DW(DW), .AW(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wrt_data(wrt_data),
        .re(re), .we(we), .hlt(hlt),
        .rd_data(rd_data), .rd_vld(rd_vld), .stall(stall), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    mem_access #(.DW(DW), .AW(AW), .TIMEOUT(4)) u_t4 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wrt_data(wrt_data),
        .re(re2), .we(we2), .hlt(hlt),
        .rd_data(rd_data2), .rd_vld(rd_vld2), .stall(stall2), .err(err2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_ack(mem_ack2), .mem_rdata(mem_rdata)
    );

    // scoreboard: every rd_vld pulse of the main instance must match the oldest expected load
    always @(negedge clk) begin
        if (rd_vld === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_vld_unexpected: got rd_vld=1 rd_data=%h, required no pulse", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    n_err++;
                    $display("FAIL rd_data_scoreboard: got %h, required %h", rd_data, mon_exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; re = 1'b0; we = 1'b0; hlt = 1'b0; re2 = 1'b0; we2 = 1'b0;
        mem_ack = 1'b0; mem_ack2 = 1'b0; addr = 16'hFFFF; wrt_data = 16'hFFFF; mem_rdata = '0;
        cyc(); cyc();
        n_chk++;
        if ({mem_req, stall, rd_vld, err, mem_we} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got req/stall/vld/err/we=%b, required 00000",
                     {mem_req, stall, rd_vld, err, mem_we});
        end
        n_chk++;
        if ({rd_data, mem_addr, mem_wdata} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_data: got rd_data=%h mem_addr=%h mem_wdata=%h, required 0",
                     rd_data, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_read();
        int n_stall, n_req;
        exp_q.push_back(16'hBEEF);
        addr = 16'h0040; re = 1'b1; #1;
        n_chk++;
        if (stall !== 1'b1 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL read_accept: got stall=%b mem_req=%b, required 1 0", stall, mem_req);
        end
        n_stall = int'(stall); n_req = int'(mem_req);
        cyc();
        re = 1'b0; addr = 16'hDEAD; mem_ack = 1'b1; mem_rdata = 16'hBEEF; #1;
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL read_wait: got req=%b addr=%h we=%b, required 1 0040 0", mem_req, mem_addr, mem_we);
        end
        n_stall += int'(stall); n_req += int'(mem_req);
        cyc();
        mem_ack = 1'b0; mem_rdata = 16'h7777; #1;
        n_chk++;
        if (rd_vld !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL read_resp: got vld=%b stall=%b req=%b, required 1 0 0", rd_vld, stall, mem_req);
        end
        n_stall += int'(stall); n_req += int'(mem_req);
        cyc();
        mem_ack = 1'b1; #1;
        n_chk++;
        if (rd_data !== 16'hBEEF || rd_vld !== 1'b0) begin
            n_err++;
            $display("FAIL read_hold: got rd_data=%h vld=%b, required beef 0", rd_data, rd_vld);
        end
        n_stall += int'(stall); n_req += int'(mem_req);
        mem_ack = 1'b0;
        n_chk++;
        if (n_stall != 2 || n_req != 1) begin
            n_err++;
            $display("FAIL read_counts: got stall_cycles=%0d req_cycles=%0d, required 2 1", n_stall, n_req);
        end
    endtask

    task automatic test_write();
        int n_stall;
        addr = 16'h0100; wrt_data = 16'h1234; we = 1'b1; #1;
        n_stall = int'(stall);
        cyc();
        we = 1'b0; addr = 16'h0000; wrt_data = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            mem_ack = (i == 4); #1;
            n_chk++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 16'h1234) begin
                n_err++;
                $display("FAIL write_wait[%0d]: got req=%b we=%b addr=%h wdata=%h, required 1 1 0100 1234",
                         i, mem_req, mem_we, mem_addr, mem_wdata);
            end
            n_stall += int'(stall);
            cyc();
        end
        mem_ack = 1'b0; #1;
        n_chk++;
        if (rd_vld !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL write_resp: got vld=%b stall=%b req=%b, required 0 0 0", rd_vld, stall, mem_req);
        end
        n_chk++;
        if (n_stall != 6) begin
            n_err++;
            $display("FAIL write_stall_cycles: got %0d, required 6", n_stall);
        end
        cyc();
    endtask

    task automatic test_timeout();
        int n_req;
        addr = 16'h0200; re2 = 1'b1; #1;
        cyc();
        re2 = 1'b0; mem_ack2 = 1'b1; mem_rdata = 16'hA5A5;
        cyc();
        mem_ack2 = 1'b0; #1;
        n_chk++;
        if (rd_vld2 !== 1'b1 || rd_data2 !== 16'hA5A5 || err2 !== 1'b0) begin
            n_err++;
            $display("FAIL t4_read: got vld=%b data=%h err=%b, required 1 a5a5 0", rd_vld2, rd_data2, err2);
        end
        cyc();
        addr = 16'h0204; wrt_data = 16'h9999; re2 = 1'b1; #1;
        cyc();
        re2 = 1'b0; addr = 16'h0000; n_req = 0;
        n_chk++;
        if (mem_addr2 !== 16'h0204 || mem_we2 !== 1'b0 || mem_wdata2 !== 16'h9999) begin
            n_err++;
            $display("FAIL t4_latch: got addr=%h we=%b wdata=%h, required 0204 0 9999", mem_addr2, mem_we2, mem_wdata2);
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_req2 !== 1'b1) break;
            n_req++;
            cyc();
        end
        n_chk++;
        if (n_req != 4) begin
            n_err++;
            $display("FAIL timeout_req_cycles: got %0d, required 4", n_req);
        end
        n_chk++;
        if (rd_vld2 !== 1'b1 || rd_data2 !== 16'h0000 || err2 !== 1'b1 || stall2 !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_resp: got vld=%b data=%h err=%b stall=%b, required 1 0000 1 0",
                     rd_vld2, rd_data2, err2, stall2);
        end
        cyc();
        mem_ack2 = 1'b1; mem_rdata = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if (mem_req2 !== 1'b0 || rd_vld2 !== 1'b0 || rd_data2 !== 16'h0000 || err2 !== 1'b1) begin
                n_err++;
                $display("FAIL late_ack[%0d]: got req=%b vld=%b data=%h err=%b, required 0 0 0000 1",
                         i, mem_req2, rd_vld2, rd_data2, err2);
            end
            cyc();
        end
        mem_ack2 = 1'b0;
        addr = 16'h0208; re2 = 1'b1; #1;
        cyc();
        re2 = 1'b0; mem_ack2 = 1'b1; mem_rdata = 16'h1357;
        cyc();
        mem_ack2 = 1'b0; #1;
        n_chk++;
        if (rd_vld2 !== 1'b1 || rd_data2 !== 16'h1357 || err2 !== 1'b1 || err !== 1'b0) begin
            n_err++;
            $display("FAIL err_sticky: got vld=%b data=%h err=%b main_err=%b, required 1 1357 1 0",
                     rd_vld2, rd_data2, err2, err);
        end
        cyc();
    endtask

    task automatic test_halt_collision();
        hlt = 1'b1; re = 1'b1; addr = 16'h0300; #1;
        n_chk++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL halt_stall: got %b, required 0", stall);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_chk++;
            if (mem_req !== 1'b0 || stall !== 1'b0) begin
                n_err++;
                $display("FAIL halt_hold[%0d]: got req=%b stall=%b, required 0 0", i, mem_req, stall);
            end
        end
        hlt = 1'b0; we = 1'b1; wrt_data = 16'h5555; #1;
        cyc();
        re = 1'b0; we = 1'b0; #1;
        n_chk++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'h5555 || mem_addr !== 16'h0300 || err !== 1'b0) begin
            n_err++;
            $display("FAIL collision_write: got req=%b we=%b wdata=%h addr=%h err=%b, required 1 1 5555 0300 0",
                     mem_req, mem_we, mem_wdata, mem_addr, err);
        end
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0; #1;
        n_chk++;
        if (rd_vld !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL collision_resp: got vld=%b err=%b, required 0 0", rd_vld, err);
        end
        cyc();
    endtask

    task automatic test_reset_mid_wait();
        re = 1'b1; re2 = 1'b1; addr = 16'h0400; #1;
        cyc();
        re = 1'b0; re2 = 1'b0;
        cyc();
        rst_n = 1'b0; #1;
        n_chk++;
        if (mem_req !== 1'b1 || mem_req2 !== 1'b1) begin
            n_err++;
            $display("FAIL rstw_in_wait: got req=%b req2=%b, required 1 1", mem_req, mem_req2);
        end
        cyc();
        rst_n = 1'b1; #1;
        n_chk++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || rd_vld !== 1'b0 || err !== 1'b0 ||
            err2 !== 1'b0 || mem_req2 !== 1'b0 || rd_vld2 !== 1'b0) begin
            n_err++;
            $display("FAIL rstw_after: got req=%b stall=%b vld=%b err=%b err2=%b req2=%b vld2=%b, required all 0",
                     mem_req, stall, rd_vld, err, err2, mem_req2, rd_vld2);
        end
        n_chk++;
        if (rd_data !== 16'h0000 || mem_addr !== 16'h0000 || rd_data2 !== 16'h0000) begin
            n_err++;
            $display("FAIL rstw_data: got rd_data=%h mem_addr=%h rd_data2=%h, required 0", rd_data, mem_addr, rd_data2);
        end
        cyc();
        n_chk++;
        if (rd_vld !== 1'b0 || rd_vld2 !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rstw_no_vld: got vld=%b vld2=%b req=%b, required 0 0 0", rd_vld, rd_vld2, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        re = 1'b1; addr = 16'h0010; #1;
        cyc();
        mem_ack = 1'b1; mem_rdata = 16'h1111; #1;
        n_chk++;
        if (mem_addr !== 16'h0010 || mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first_wait: got addr=%h req=%b, required 0010 1", mem_addr, mem_req);
        end
        cyc();
        mem_ack = 1'b0; mem_rdata = 16'h0000; addr = 16'h0020; #1;
        n_chk++;
        if (rd_vld !== 1'b1 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first_resp: got vld=%b stall=%b, required 1 0", rd_vld, stall);
        end
        cyc();
        n_chk++;
        if (stall !== 1'b1 || rd_vld !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_accept: got stall=%b vld=%b, required 1 0", stall, rd_vld);
        end
        cyc();
        re = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h2222; #1;
        n_chk++;
        if (mem_addr !== 16'h0020 || mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second_wait: got addr=%h req=%b, required 0020 1", mem_addr, mem_req);
        end
        cyc();
        mem_ack = 1'b0; #1;
        n_chk++;
        if (rd_vld !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second_resp: got vld=%b, required 1", rd_vld);
        end
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_halt_collision();
        test_reset_mid_wait();
        test_back_to_back();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending loads, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DW, 16, data width.
- AW, 16, address width.
- TIMEOUT, 255, maximum WAIT cycles without mem_ack before abort (legal range 1..255).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- addr  in  AW  effective address from execute stage (ALU dst).
- wrt_data  in  DW  store data from execute stage (register p1).
- re  in  1  load request from decode.
- we  in  1  store request from decode.
- hlt  in  1  processor halted; blocks new accesses.
- rd_data  out  DW  load result toward register write-back.
- rd_vld  out  1  one-cycle pulse; rd_data valid.
- stall  out  1  freeze PC and upstream stages.
- err  out  1  sticky bus-timeout flag.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  AW  registered address.
- mem_wdata  out  DW  registered write data.
- mem_ack  in  1  memory completion, sampled only in WAIT.
- mem_rdata  in  DW  read data, valid with mem_ack.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-004 In IDLE with (re|we)=1 and hlt=0, the block SHALL latch addr, wrt_data and we into mem_addr, mem_wdata and mem_we, clear the timeout counter, and go to WAIT.
REQ-005 When re=we=1 in IDLE, the access SHALL be a write; err SHALL remain unchanged.
REQ-006 In IDLE with hlt=1, the block SHALL accept no access and SHALL stay in IDLE.
REQ-007 mem_req SHALL equal 1 exactly while the state is WAIT; mem_addr, mem_we and mem_wdata SHALL stay constant throughout WAIT.
REQ-008 In WAIT with mem_ack=1, the block SHALL go to RESP; for a read it SHALL register mem_rdata into rd_data on that edge.
REQ-009 In WAIT with mem_ack=0, the counter SHALL increment; when the counter equals TIMEOUT-1, the block SHALL go to RESP, set err=1 and load rd_data with 0.
REQ-010 In RESP, the block SHALL drive rd_vld=1 for a completed read or a timed-out read, rd_vld=0 for a write, and SHALL go to IDLE unconditionally.
REQ-011 stall SHALL be combinational: 1 when (IDLE and (re|we) and !hlt) or WAIT; 0 otherwise, including RESP.
REQ-012 Minimum latency: accept edge, then mem_ack in the first WAIT cycle, then RESP with rd_vld. This SHALL produce 2 stall cycles and rd_vld in cycle 2 after acceptance.
REQ-013 mem_ack and mem_rdata SHALL be ignored in IDLE and RESP, so a late ack after a timeout has no effect.
REQ-014 rd_data SHALL hold its last value except on the updates in REQ-008 and REQ-009.
REQ-015 Once set, err SHALL remain 1 until reset.

Reset
REQ-016 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear the counter, rd_data, mem_addr, mem_wdata, mem_we and err to 0.
REQ-017 Reset SHALL take priority over every transition, including in WAIT. mem_req SHALL be 0 from the first post-reset cycle, and the aborted access SHALL produce no rd_vld.

Structure
REQ-018 The state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10) and the default TIMEOUT SHALL live in the shared CPU definitions package.
REQ-019 The timeout counter SHALL be a sub-module, timeout_ctr (clear, enable, terminal-count output). The remaining logic SHALL be a single module placed after EX in cpu.

Verification
REQ-020 Read, ack on the first WAIT cycle: addr=16'h0040, re=1, mem_rdata=16'hBEEF -> mem_req high 1 cycle, stall high 2 cycles, rd_vld pulse with rd_data=16'hBEEF.
REQ-021 Write, ack after 5 WAIT cycles: addr=16'h0100, wrt_data=16'h1234, we=1 -> mem_we=1, mem_addr/mem_wdata stable for 5 cycles, stall high 6 cycles, rd_vld=0.
REQ-022 Timeout: TIMEOUT=4, re=1, mem_ack=0 -> mem_req high 4 cycles, then RESP with rd_data=0, rd_vld=1 and err=1 sticky; a late mem_ack in IDLE is ignored.
REQ-023 Halt and collision: hlt=1 with re=1 -> no mem_req, stall=0. re=we=1 with hlt=0 -> write performed.
REQ-024 Reset mid-WAIT: rst_n=0 on the 2nd WAIT cycle -> next cycle IDLE, mem_req=0, err=0, no rd_vld.
REQ-025 Back-to-back loads: two consecutive load instructions -> each gets a separate IDLE-WAIT-RESP sequence and two rd_vld pulses, in order, with correct data.
